nunchuk_poll_sequencer: RTL and testbench

- Transaction sequencer between the I2C master and the rest of the nunchuk driver.
- After reset it runs the unencrypted init sequence, then periodically reads the 6-byte nunchuk report.
- Decodes each report into registered stick, accelerometer and button outputs.
- Owns the I2C master's command interface (`deviceAddr`/`addr`/`numBytes`/`dataIn`/`write`/`start`) and consumes its `dataOut`/`done`.

---
 rtl/nunchuk_pkg.sv | 46 ++++
 rtl/nunchuk_decode.sv | 48 ++++
 rtl/nunchuk_poll_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_nunchuk_poll_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nunchuk_pkg.sv
// Shared types and constants for the nunchuk poll sequencer.
// Optional feature macro: NUNCHUK_DEADZONE_EN (stick deadzone in nunchuk_decode).
package nunchuk_pkg;

  // FSM encoding, kept as plain constants for legacy tool compatibility
  typedef logic [3:0] state_t;
  localparam state_t StBoot      = 4'd0;
  localparam state_t StInit1     = 4'd1;
  localparam state_t StInit1Wait = 4'd2;
  localparam state_t StInit2     = 4'd3;
  localparam state_t StInit2Wait = 4'd4;
  localparam state_t StIdle      = 4'd5;
  localparam state_t StPtr       = 4'd6;
  localparam state_t StPtrWait   = 4'd7;
  localparam state_t StSettle    = 4'd8;
  localparam state_t StRead      = 4'd9;
  localparam state_t StReadWait  = 4'd10;
  localparam state_t StUpdate    = 4'd11;

  // Unencrypted init sequence and data register
  localparam logic [7:0] REG_ENC1 = 8'hF0;
  localparam logic [7:0] VAL_ENC1 = 8'h55;
  localparam logic [7:0] REG_ENC2 = 8'hFB;
  localparam logic [7:0] VAL_ENC2 = 8'h00;
  localparam logic [7:0] REG_DATA = 8'h00;

  localparam int unsigned REPORT_BYTES = 6;

  typedef struct packed {
    logic [7:0] stick_x;
    logic [7:0] stick_y;
    logic [9:0] accel_x;
    logic [9:0] accel_y;
    logic [9:0] accel_z;
    logic       z;
    logic       c;
  } nunchuk_sample_t;

  // Stick centred, accelerometers at mid-scale, buttons released
  localparam nunchuk_sample_t SAMPLE_RESET = '{
    stick_x: 8'h80, stick_y: 8'h80,
    accel_x: 10'd512, accel_y: 10'd512, accel_z: 10'd512,
    z: 1'b0, c: 1'b0
  };

endpackage

// File: rtl/nunchuk_decode.sv
// Combinational decode of a raw 6-byte nunchuk report (byte0 in [7:0]).
// Flags an all-ones report as a bad read (device absent or not initialised).
// With NUNCHUK_DEADZONE_EN defined, stick values near centre snap to 8'h80.
module nunchuk_decode
  import nunchuk_pkg::*;
`ifdef NUNCHUK_DEADZONE_EN
#(
  parameter int unsigned DEADZONE = 8
)
`endif
(
  input  logic [8*REPORT_BYTES-1:0] raw,
  output nunchuk_sample_t           sample,
  output logic                      bad
);

`ifdef NUNCHUK_DEADZONE_EN
  // Window is 128 +/- DEADZONE, inclusive at both ends
  function automatic logic [7:0] apply_deadzone(input logic [7:0] v);
    int val;
    val = int'({24'd0, v});
    if ((val >= 128 - int'(DEADZONE)) && (val <= 128 + int'(DEADZONE))) begin
      return 8'h80;
    end
    return v;
  endfunction
`endif

  // Field extraction; buttons are active-low on the wire
  always_comb begin
    sample = SAMPLE_RESET;
`ifdef NUNCHUK_DEADZONE_EN
    sample.stick_x = apply_deadzone(raw[7:0]);
    sample.stick_y = apply_deadzone(raw[15:8]);
`else
    sample.stick_x = raw[7:0];
    sample.stick_y = raw[15:8];
`endif
    sample.accel_x = {raw[23:16], raw[43:42]};
    sample.accel_y = {raw[31:24], raw[45:44]};
    sample.accel_z = {raw[39:32], raw[47:46]};
    sample.z       = ~raw[40];
    sample.c       = ~raw[41];
  end

  assign bad = &raw;

endmodule

// File: rtl/nunchuk_poll_sequencer.sv
// Drives the I2C master: runs the unencrypted init sequence after reset, then
// periodically reads the 6-byte report and publishes decoded registered outputs.
// Optional feature macro: NUNCHUK_DEADZONE_EN (adds DEADZONE parameter).
module nunchuk_poll_sequencer
  import nunchuk_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h52,
  parameter int unsigned INIT_DELAY  = 50000,
  parameter int unsigned POLL_PERIOD = 500000,
  parameter int unsigned SETTLE      = 2000,
  parameter int unsigned TIMEOUT     = 100000
`ifdef NUNCHUK_DEADZONE_EN
  ,
  parameter int unsigned DEADZONE    = 8
`endif
) (
  input  logic        clock,
  input  logic        reset,
  output logic [6:0]  i2c_device_addr,
  output logic [7:0]  i2c_addr,
  output logic [2:0]  i2c_num_bytes,
  output logic [7:0]  i2c_data_in,
  output logic        i2c_write,
  output logic        i2c_start,
  input  logic [47:0] i2c_data_out,
  input  logic        i2c_done,
  output logic [7:0]  stick_x,
  output logic [7:0]  stick_y,
  output logic [9:0]  accel_x,
  output logic [9:0]  accel_y,
  output logic [9:0]  accel_z,
  output logic        z,
  output logic        c,
  output logic        sample_valid,
  output logic        ready,
  output logic        error
);

  state_t          state_q, state_d;
  logic [31:0]     cnt_q, poll_q;
  logic            ready_q, error_q, sample_valid_q;
  logic [47:0]     raw_q;
  nunchuk_sample_t sample_q, dec_sample;
  logic            dec_bad;
  logic            in_wait, wait_expired, poll_tick, init_done, fatal;

`ifdef NUNCHUK_DEADZONE_EN
  nunchuk_decode #(.DEADZONE(DEADZONE)) u_decode (
    .raw    (raw_q),
    .sample (dec_sample),
    .bad    (dec_bad)
  );
`else
  nunchuk_decode u_decode (
    .raw    (raw_q),
    .sample (dec_sample),
    .bad    (dec_bad)
  );
`endif

  // Event decode shared by next-state and status logic
  always_comb begin
    in_wait = (state_q == StInit1Wait) || (state_q == StInit2Wait) ||
              (state_q == StPtrWait)   || (state_q == StReadWait);
    wait_expired = in_wait && !i2c_done && (cnt_q + 32'd1 >= TIMEOUT);
    poll_tick    = ready_q && (poll_q + 32'd1 >= POLL_PERIOD);
    init_done    = (state_q == StInit2Wait) && i2c_done;
    fatal        = wait_expired || ((state_q == StUpdate) && dec_bad);
  end

  // Next-state logic; any fatal condition forces a full re-init from BOOT
  always_comb begin
    state_d = state_q;
    case (state_q)
      StBoot:      if (cnt_q + 32'd1 >= INIT_DELAY) state_d = StInit1;
      StInit1:     state_d = StInit1Wait;
      StInit1Wait: if (i2c_done) state_d = StInit2;
      StInit2:     state_d = StInit2Wait;
      StInit2Wait: if (i2c_done) state_d = StIdle;
      StIdle:      if (poll_tick) state_d = StPtr;
      StPtr:       state_d = StPtrWait;
      StPtrWait:   if (i2c_done) state_d = StSettle;
      StSettle:    if (cnt_q + 32'd1 >= SETTLE) state_d = StRead;
      StRead:      state_d = StReadWait;
      StReadWait:  if (i2c_done) state_d = StUpdate;
      StUpdate:    state_d = StIdle;
      default:     state_d = StBoot;
    endcase
    if (fatal) state_d = StBoot;
  end

  // State register and per-state cycle counter (restarts on every transition)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StBoot;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
    end
  end

  // Poll counter: free-running once ready; ticks landing outside IDLE are dropped
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      poll_q <= '0;
    end else if (init_done) begin
      poll_q <= '0;
    end else if (ready_q) begin
      poll_q <= poll_tick ? 32'd0 : poll_q + 32'd1;
    end
  end

  // Ready/error status; error is sticky until the next successful init
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else if (init_done) begin
      ready_q <= 1'b1;
      error_q <= 1'b0;
    end else if (fatal) begin
      ready_q <= 1'b0;
      error_q <= 1'b1;
    end
  end

  // Command fields load on entry to a command state and hold until done
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i2c_addr      <= '0;
      i2c_data_in   <= '0;
      i2c_num_bytes <= '0;
      i2c_write     <= 1'b0;
    end else if (state_d != state_q) begin
      case (state_d)
        StInit1: begin
          i2c_addr      <= REG_ENC1;
          i2c_data_in   <= VAL_ENC1;
          i2c_num_bytes <= 3'd1;
          i2c_write     <= 1'b1;
        end
        StInit2: begin
          i2c_addr      <= REG_ENC2;
          i2c_data_in   <= VAL_ENC2;
          i2c_num_bytes <= 3'd1;
          i2c_write     <= 1'b1;
        end
        StPtr: begin
          i2c_addr      <= REG_DATA;
          i2c_data_in   <= 8'h00;
          i2c_num_bytes <= 3'd0;
          i2c_write     <= 1'b1;
        end
        StRead: begin
          i2c_addr      <= 8'h00;
          i2c_data_in   <= 8'h00;
          i2c_num_bytes <= 3'(REPORT_BYTES);
          i2c_write     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Capture the report on read completion; decoded during UPDATE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      raw_q <= '0;
    end else if ((state_q == StReadWait) && i2c_done) begin
      raw_q <= i2c_data_out;
    end
  end

  // Output sample register; a bad read leaves the previous sample in place
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_q       <= SAMPLE_RESET;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      if ((state_q == StUpdate) && !dec_bad) begin
        sample_q       <= dec_sample;
        sample_valid_q <= 1'b1;
      end
    end
  end

  // Start is decoded from the registered state, so async reset clears it at once
  assign i2c_start = (state_q == StInit1) || (state_q == StInit2) ||
                     (state_q == StPtr)   || (state_q == StRead);

  assign i2c_device_addr = DEV_ADDR;
  assign stick_x         = sample_q.stick_x;
  assign stick_y         = sample_q.stick_y;
  assign accel_x         = sample_q.accel_x;
  assign accel_y         = sample_q.accel_y;
  assign accel_z         = sample_q.accel_z;
  assign z               = sample_q.z;
  assign c               = sample_q.c;
  assign sample_valid    = sample_valid_q;
  assign ready           = ready_q;
  assign error           = error_q;

endmodule

// File: tb/tb_nunchuk_poll_sequencer.sv
// Directed bench for nunchuk_poll_sequencer with a small I2C master responder.
// Build with NUNCHUK_DEADZONE_EN to exercise the stick deadzone expectations.
module tb_nunchuk_poll_sequencer;

  localparam int unsigned INIT_DELAY  = 20;
  localparam int unsigned POLL_PERIOD = 400;
  localparam int unsigned SETTLE      = 5;
  localparam int unsigned TIMEOUT     = 300;
  localparam int unsigned ACK_LAT     = 100;
  localparam int unsigned WAIT_MAX    = 5000;

`ifdef NUNCHUK_DEADZONE_EN
  localparam logic [7:0] DZ_X_EXP = 8'h80;
`else
  localparam logic [7:0] DZ_X_EXP = 8'h87;
`endif

  localparam logic [19:0] CMD_INIT1 = {8'hF0, 8'h55, 3'd1, 1'b1};
  localparam logic [19:0] CMD_INIT2 = {8'hFB, 8'h00, 3'd1, 1'b1};
  localparam logic [19:0] CMD_PTR   = {8'h00, 8'h00, 3'd0, 1'b1};
  localparam logic [19:0] CMD_READ  = {8'h00, 8'h00, 3'd6, 1'b0};

  logic        clock, reset;
  logic [6:0]  i2c_device_addr;
  logic [7:0]  i2c_addr, i2c_data_in;
  logic [2:0]  i2c_num_bytes;
  logic        i2c_write, i2c_start, i2c_done;
  logic [47:0] i2c_data_out;
  logic [7:0]  stick_x, stick_y;
  logic [9:0]  accel_x, accel_y, accel_z;
  logic        z, c, sample_valid, ready, error;

  nunchuk_poll_sequencer #(
    .DEV_ADDR    (7'h52),
    .INIT_DELAY  (INIT_DELAY),
    .POLL_PERIOD (POLL_PERIOD),
    .SETTLE      (SETTLE),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .i2c_device_addr (i2c_device_addr),
    .i2c_addr        (i2c_addr),
    .i2c_num_bytes   (i2c_num_bytes),
    .i2c_data_in     (i2c_data_in),
    .i2c_write       (i2c_write),
    .i2c_start       (i2c_start),
    .i2c_data_out    (i2c_data_out),
    .i2c_done        (i2c_done),
    .stick_x         (stick_x),
    .stick_y         (stick_y),
    .accel_x         (accel_x),
    .accel_y         (accel_y),
    .accel_z         (accel_z),
    .z               (z),
    .c               (c),
    .sample_valid    (sample_valid),
    .ready           (ready),
    .error           (error)
  );

  int unsigned tests_run, tests_failed;
  int unsigned cyc;

  // Responder state and command log
  logic [7:0]  log_addr[$];
  logic [7:0]  log_data[$];
  logic [2:0]  log_n[$];
  logic        log_wr[$];
  int unsigned log_cyc[$];
  logic        hang_reads;
  logic [47:0] read_data;
  int unsigned ptr_done_cyc;
  int unsigned proto_err, sv_cnt, sv_double;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] cmd_at(input int unsigned i);
    if (i < log_addr.size()) return {log_addr[i], log_data[i], log_n[i], log_wr[i]};
    return '1;
  endfunction

  function automatic int unsigned cmd_cyc(input int unsigned i);
    if (i < log_cyc.size()) return log_cyc[i];
    return 0;
  endfunction

  // I2C master model: logs each start, acks after ACK_LAT cycles, checks field stability
  initial begin : responder
    int unsigned remaining;
    logic        busy;
    logic [19:0] cur;
    busy = 1'b0;
    remaining = 0;
    cur = '0;
    i2c_done = 1'b0;
    i2c_data_out = '0;
    forever begin
      @(negedge clock);
      i2c_done = 1'b0;
      if (reset) begin
        busy = 1'b0;
      end else if (busy) begin
        if (i2c_start || ({i2c_addr, i2c_data_in, i2c_num_bytes, i2c_write} != cur)) proto_err++;
        remaining--;
        if (remaining == 0) begin
          busy = 1'b0;
          i2c_done = 1'b1;
          if (!cur[0]) i2c_data_out = read_data;
          if (cur == CMD_PTR) ptr_done_cyc = cyc;
        end
      end else if (i2c_start) begin
        log_addr.push_back(i2c_addr);
        log_data.push_back(i2c_data_in);
        log_n.push_back(i2c_num_bytes);
        log_wr.push_back(i2c_write);
        log_cyc.push_back(cyc);
        if (i2c_write || !hang_reads) begin
          busy = 1'b1;
          remaining = ACK_LAT;
          cur = {i2c_addr, i2c_data_in, i2c_num_bytes, i2c_write};
        end
      end
    end
  end

  // sample_valid monitor: pulse count and back-to-back detection
  initial begin : sv_monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (sample_valid && prev) sv_double++;
      if (sample_valid) sv_cnt++;
      prev = sample_valid;
    end
  end

  task automatic wait_ready(input string tag);
    int unsigned n = 0;
    while (ready !== 1'b1 && n < WAIT_MAX) begin @(negedge clock); n++; end
    check(tag, 64'(ready), 64'd1);
  endtask

  task automatic wait_sv(input string tag);
    int unsigned n = 0;
    while (sample_valid !== 1'b1 && n < WAIT_MAX) begin @(negedge clock); n++; end
    check(tag, 64'(sample_valid), 64'd1);
  endtask

  task automatic wait_error(input string tag);
    int unsigned n = 0;
    while (error !== 1'b1 && n < WAIT_MAX) begin @(negedge clock); n++; end
    check(tag, 64'(error), 64'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned rel_cyc, ready_cyc, err_cyc, n0, sv0, wait_n;
    tests_run = 0;
    tests_failed = 0;
    proto_err = 0;
    sv_cnt = 0;
    sv_double = 0;
    ptr_done_cyc = 0;
    hang_reads = 1'b0;
    read_data = 48'hF3A090_80817F;
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Reset values
    check("rst_stick", {stick_x, stick_y}, 16'h8080);
    check("rst_accel", {accel_x, accel_y, accel_z}, {10'd512, 10'd512, 10'd512});
    check("rst_flags", {z, c, sample_valid, ready, error, i2c_start}, 6'b0);
    check("rst_cmd", {i2c_write, i2c_addr, i2c_num_bytes, i2c_data_in}, 20'h0);
    check("dev_addr", i2c_device_addr, 7'h52);

    // Init sequence and first poll
    reset = 1'b0;
    rel_cyc = cyc;
    wait_ready("init_ready");
    ready_cyc = cyc;
    check("init_error", error, 1'b0);
    check("init1_cmd", cmd_at(0), CMD_INIT1);
    check("init2_cmd", cmd_at(1), CMD_INIT2);
    check("init1_delay", cmd_cyc(0) - rel_cyc, INIT_DELAY);

    wait_sv("poll1_sv");
    check("ptr_cmd", cmd_at(2), CMD_PTR);
    check("read_cmd", cmd_at(3), CMD_READ);
    check("ptr_time", cmd_cyc(2) - ready_cyc, POLL_PERIOD);
    check("settle_gap", cmd_cyc(3) - ptr_done_cyc, SETTLE + 1);
    check("v1_stick", {stick_x, stick_y}, 16'h7F81);
    check("v1_accel", {accel_x, accel_y, accel_z}, {10'h200, 10'h243, 10'h283});
    check("v1_btn", {z, c}, 2'b00);
    @(negedge clock);
    check("v1_sv_pulse", sample_valid, 1'b0);

    // Buttons pressed, low accel bits all ones
    read_data = 48'hFCA090_80817F;
    wait_sv("poll2_sv");
    check("v2_btn", {z, c}, 2'b11);
    check("v2_accel", {accel_x, accel_y, accel_z}, {10'h203, 10'h243, 10'h283});
    @(negedge clock);

    // Stick near centre (deadzone window when enabled)
    read_data = 48'hF3A090_808987;
    wait_sv("poll3_sv");
    check("v3_stick", {stick_x, stick_y}, {DZ_X_EXP, 8'h89});
    check("v3_btn", {z, c}, 2'b00);
    @(negedge clock);

    // Read never completes: timeout, re-init, error clears after INIT2
    hang_reads = 1'b1;
    n0 = log_addr.size();
    sv0 = sv_cnt;
    wait_error("to_error");
    err_cyc = cyc;
    check("to_ready", ready, 1'b0);
    check("to_read_cmd", cmd_at(n0 + 1), CMD_READ);
    check("to_time", err_cyc - cmd_cyc(n0 + 1), TIMEOUT + 1);
    check("to_hold", {stick_x, stick_y, accel_x, z, c}, {DZ_X_EXP, 8'h89, 10'h200, 2'b00});
    check("to_no_sv", sv_cnt, sv0);
    hang_reads = 1'b0;
    read_data = 48'hFFFFFF_FFFFFF;
    wait_ready("to_reinit_ready");
    check("to_reinit1", cmd_at(n0 + 2), CMD_INIT1);
    check("to_reinit2", cmd_at(n0 + 3), CMD_INIT2);
    check("to_error_clr", error, 1'b0);

    // All-ones report: rejected, outputs hold, re-init
    sv0 = sv_cnt;
    wait_error("bad_error");
    check("bad_no_sv", sv_cnt, sv0);
    check("bad_hold", {stick_x, stick_y, accel_y}, {DZ_X_EXP, 8'h89, 10'h243});
    read_data = 48'hF3A090_80817F;
    wait_ready("bad_reinit_ready");
    check("bad_error_clr", error, 1'b0);

    // Async reset while the pointer write is outstanding
    n0 = log_addr.size();
    wait_n = 0;
    while (log_addr.size() == n0 && wait_n < WAIT_MAX) begin @(negedge clock); wait_n++; end
    check("rr_ptr_cmd", cmd_at(n0), CMD_PTR);
    repeat (10) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("rr_start", i2c_start, 1'b0);
    check("rr_stick", {stick_x, stick_y}, 16'h8080);
    check("rr_accel", {accel_x, accel_y, accel_z}, {10'd512, 10'd512, 10'd512});
    check("rr_flags", {ready, error, sample_valid}, 3'b000);
    @(negedge clock);
    reset = 1'b0;
    rel_cyc = cyc;
    wait_ready("rr_ready");
    check("rr_init1", cmd_at(n0 + 1), CMD_INIT1);
    check("rr_init_delay", cmd_cyc(n0 + 1) - rel_cyc, INIT_DELAY);

    check("protocol", proto_err, 0);
    check("sv_single", sv_double, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
